// File: rtl/spi_flash_reader.sv
// SPI mode-0 READ (0x03) engine answering the core's spi_enable/spi_ack fetch handshake.
// Fetches four bytes starting at FLASH_BASE + addr and returns them as one little-endian word.
module spi_flash_reader #(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned ADDR_W     = 22,
    parameter logic [23:0] FLASH_BASE = 24'h100000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_enable,
    input  logic [ADDR_W-1:0] addr,
    output logic [31:0]       spi_data,
    output logic              spi_ack,
    output logic              spi_sclk,
    output logic              spi_cs_n,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        ACK
    } state_t;

    localparam int unsigned PH_LAST = CLK_DIV - 1;

    state_t             state_q;
    logic [31:0]        tx_q;
    logic [31:0]        rx_q;
    logic [31:0]        data_q;
    logic [6:0]         bit_q;
    logic [CLK_DIV-1:0] phase_q;
    logic               ack_q;
    logic               sclk_q;
    logic               cs_n_q;
    logic               mosi_q;

    logic [23:0]        faddr_d;
    logic [31:0]        tx_d;
    logic               phase_end;

    assign faddr_d   = FLASH_BASE + 24'(addr);
    assign tx_d      = {8'h03, faddr_d};
    assign phase_end = (32'(phase_q) == PH_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            bit_q   <= '0;
            phase_q <= '0;
            ack_q   <= 1'b0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (spi_enable) begin
                        tx_q    <= tx_d;
                        cs_n_q  <= 1'b0;
                        sclk_q  <= 1'b0;
                        mosi_q  <= tx_d[31];
                        state_q <= SETUP;
                    end
                end
                SETUP: begin
                    phase_q <= '0;
                    bit_q   <= '0;
                    state_q <= SHIFT;
                end
                SHIFT: begin
                    if (!phase_end) begin
                        phase_q <= phase_q + CLK_DIV'(1);
                    end else begin
                        phase_q <= '0;
                        if (!sclk_q) begin
                            sclk_q <= 1'b1;
                            // bits 32..63 carry the read data
                            if (bit_q[5]) begin
                                rx_q <= {rx_q[30:0], spi_miso};
                            end
                        end else begin
                            sclk_q <= 1'b0;
                            if (bit_q == 7'd63) begin
                                cs_n_q  <= 1'b1;
                                mosi_q  <= 1'b0;
                                state_q <= HOLD;
                            end else begin
                                // tx drains to zero after 32 shifts, so MOSI idles low during data
                                bit_q  <= bit_q + 7'd1;
                                tx_q   <= {tx_q[30:0], 1'b0};
                                mosi_q <= tx_q[30];
                            end
                        end
                    end
                end
                HOLD: begin
                    data_q  <= {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                    ack_q   <= 1'b1;
                    state_q <= ACK;
                end
                ACK: begin
                    if (!spi_enable) begin
                        ack_q   <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign spi_data = data_q;
    assign spi_ack  = ack_q;
    assign spi_sclk = sclk_q;
    assign spi_cs_n = cs_n_q;
    assign spi_mosi = mosi_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Randomised bench for spi_flash_reader: two instances (default base / wrapping base)
// share one behavioural serial-flash model and a word-level expected-value model.
module tb_spi_flash_reader;

    localparam int          DIV0  = 2;
    localparam int          DIV1  = 1;
    localparam logic [23:0] BASE0 = 24'h100000;
    localparam logic [23:0] BASE1 = 24'hFFFFFE;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sel;
    logic [21:0] addr;
    logic        miso;

    logic        en0, en1;
    logic [31:0] data0, data1;
    logic        ack0, ack1, sclk0, sclk1, cs0, cs1, mosi0, mosi1;
    logic [31:0] m_data;
    logic        m_ack, m_sclk, m_cs_n, m_mosi;

    int          n_checks;
    int          n_pass;
    logic [31:0] exp_data [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign en0    = en & ~sel;
    assign en1    = en & sel;
    assign m_data = sel ? data1 : data0;
    assign m_ack  = sel ? ack1  : ack0;
    assign m_sclk = sel ? sclk1 : sclk0;
    assign m_cs_n = sel ? cs1   : cs0;
    assign m_mosi = sel ? mosi1 : mosi0;

    spi_flash_reader #(
        .CLK_DIV    (DIV0),
        .ADDR_W     (22),
        .FLASH_BASE (BASE0)
    ) u_dut0 (
        .clk        (clk),
        .reset      (rst_n),
        .spi_enable (en0),
        .addr       (addr),
        .spi_data   (data0),
        .spi_ack    (ack0),
        .spi_sclk   (sclk0),
        .spi_cs_n   (cs0),
        .spi_mosi   (mosi0),
        .spi_miso   (miso)
    );

    spi_flash_reader #(
        .CLK_DIV    (DIV1),
        .ADDR_W     (22),
        .FLASH_BASE (BASE1)
    ) u_dut1 (
        .clk        (clk),
        .reset      (rst_n),
        .spi_enable (en1),
        .addr       (addr),
        .spi_data   (data1),
        .spi_ack    (ack1),
        .spi_sclk   (sclk1),
        .spi_cs_n   (cs1),
        .spi_mosi   (mosi1),
        .spi_miso   (miso)
    );

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        case (a)
            24'h100010: return 8'h78;
            24'h100011: return 8'h56;
            24'h100012: return 8'h34;
            24'h100013: return 8'h12;
            24'h000001: return 8'hAA;
            24'h000002: return 8'hBB;
            24'h000003: return 8'hCC;
            24'h000004: return 8'hDD;
            default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5C;
        endcase
    endfunction

    // serial flash: counts SCLK rises under CS, records command, serves bytes after bit 32
    int          f_bits, f_merr, f_last_rises, f_last_merr;
    logic [31:0] f_cmd, f_last_cmd;

    always @(posedge m_sclk or posedge m_cs_n) begin
        if (m_cs_n) begin
            f_last_cmd   = f_cmd;
            f_last_rises = f_bits;
            f_last_merr  = f_merr;
            f_bits       = 0;
            f_cmd        = '0;
            f_merr       = 0;
        end else begin
            if (f_bits < 32) f_cmd = {f_cmd[30:0], m_mosi};
            else if (m_mosi !== 1'b0) f_merr++;
            f_bits++;
        end
    end

    always @(negedge m_sclk) begin
        int k;
        logic [7:0] b;
        if (!m_cs_n && f_bits >= 32 && f_bits < 64) begin
            k    = f_bits - 32;
            b    = flash_byte(f_cmd[23:0] + 24'(k / 8));
            miso = b[7 - (k % 8)];
        end else begin
            miso = 1'($urandom);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic do_read(input logic inst, input logic [21:0] a, input int drop_at,
                           input int hold, input int rst_at);
        int          lat;
        int          n;
        bit          got_ack;
        logic [23:0] fa;
        logic [31:0] exp;
        lat = 2 + 128 * (inst ? DIV1 : DIV0);
        fa  = 24'((32'(inst ? BASE1 : BASE0) + 32'(a)) % 32'h0100_0000);
        exp = {flash_byte(fa + 24'd3), flash_byte(fa + 24'd2),
               flash_byte(fa + 24'd1), flash_byte(fa)};
        sel = inst;
        addr = a;
        en = 1'b1;
        n = 0;
        got_ack = 0;
        while (n < lat + 20) begin
            @(posedge clk); #1;
            if (m_ack) begin
                got_ack = 1;
                break;
            end
            n++;
            if (n == 3) addr = 22'($urandom);
            if (n == drop_at) en = 1'b0;
            if (n == rst_at) break;
        end
        if (rst_at > 0 && n == rst_at) begin
            check("busy_before_reset", 32'(m_cs_n), 32'd0);
            rst_n = 1'b0;
            en = 1'b0;
            @(posedge clk); #1;
            check("abort_cs_n", 32'(m_cs_n), 32'd1);
            check("abort_sclk", 32'(m_sclk), 32'd0);
            check("abort_ack", 32'(m_ack), 32'd0);
            check("abort_data", m_data, 32'd0);
            rst_n = 1'b1;
            exp_data[0] = '0;
            exp_data[1] = '0;
            return;
        end
        if (!got_ack) begin
            check("ack_timeout", 32'(got_ack), 32'd1);
            en = 1'b0;
            repeat (lat) @(posedge clk);
            #1;
            return;
        end
        check("latency", 32'(n), 32'(lat));
        check("data", m_data, exp);
        check("cmd", f_last_cmd, {8'h03, fa});
        check("sclk_rises", 32'(f_last_rises), 32'd64);
        check("mosi_tail", 32'(f_last_merr), 32'd0);
        exp_data[inst] = exp;
        if (drop_at > 0) begin
            @(posedge clk); #1;
            check("ack_pulse", 32'(m_ack), 32'd0);
            check("data_kept", m_data, exp);
        end else begin
            repeat (hold) begin
                @(posedge clk); #1;
                check("ack_held", 32'(m_ack), 32'd1);
            end
            en = 1'b0;
            @(posedge clk); #1;
            check("ack_drop", 32'(m_ack), 32'd0);
            check("data_kept", m_data, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst_n = 1'b0;
        en = 1'b0;
        sel = 1'b0;
        addr = '0;
        miso = 1'b0;
        exp_data[0] = '0;
        exp_data[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", {cs1, cs0}, 32'd3);
        check("rst_sclk", {sclk1, sclk0}, 32'd0);
        check("rst_mosi", {mosi1, mosi0}, 32'd0);
        check("rst_ack", {ack1, ack0}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle_cs_n", {cs1, cs0}, 32'd3);
            check("idle_sclk", {sclk1, sclk0}, 32'd0);
            check("idle_ack", {ack1, ack0}, 32'd0);
            check("idle_data0", data0, 32'd0);
            check("idle_data1", data1, 32'd0);
        end

        do_read(1'b0, 22'h000010, 0, 10, 0);
        do_read(1'b0, 22'h000004, 0, 2, 0);
        do_read(1'b1, 22'h000003, 0, 3, 0);
        do_read(1'b1, 22'h000000, 0, 0, 0);
        do_read(1'b0, 22'($urandom), 50, 0, 0);
        do_read(1'b0, 22'($urandom), 0, 0, 100);
        check("post_reset_data1", data1, 32'd0);
        do_read(1'b0, 22'h3FFFFF, 0, 1, 0);

        for (int i = 0; i < 14; i++) begin
            logic inst;
            int   lat;
            int   drop;
            inst = 1'($urandom_range(0, 1));
            lat  = 2 + 128 * (inst ? DIV1 : DIV0);
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat)) : 0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            check("hold_data0", data0, exp_data[0]);
            check("hold_data1", data1, exp_data[1]);
            do_read(inst, 22'($urandom), drop, int'($urandom_range(0, 4)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
